// File: rtl/mpw_mux_pkg.sv
// Shared types and helpers for the multi-project pad mux: FSM states,
// request classification and the pad tristate default.
package mpw_mux_pkg;

  typedef enum logic [1:0] {IDLE, GUARD, RUN} state_e;

  typedef enum logic [1:0] {REQ_ZERO, REQ_ONEHOT, REQ_MULTI} req_class_e;

  localparam logic OEB_DEFAULT = 1'b1;

  // Callers zero-extend their request vector; NUM_PROJ never exceeds 32.
  function automatic req_class_e classify_req(input logic [31:0] v);
    if (v == 32'd0) begin
      return REQ_ZERO;
    end else if ((v & (v - 32'd1)) == 32'd0) begin
      return REQ_ONEHOT;
    end else begin
      return REQ_MULTI;
    end
  endfunction

endpackage

// File: rtl/mpw_slice_select.sv
// One-hot indexed slice mux: returns the IO_W-bit slice selected by i_sel,
// or all zeros when i_sel is zero.
module mpw_slice_select
  import mpw_mux_pkg::*;
#(
  parameter int NUM_PROJ = 8,
  parameter int IO_W     = 38
) (
  input  logic [NUM_PROJ-1:0]      i_sel,
  input  logic [NUM_PROJ*IO_W-1:0] i_data,
  output logic [IO_W-1:0]          o_slice
);

  logic [IO_W-1:0] w_masked [NUM_PROJ];

  generate
    for (genvar gi = 0; gi < NUM_PROJ; gi++) begin : g_mask
      assign w_masked[gi] = i_sel[gi] ? i_data[gi*IO_W +: IO_W] : '0;
    end
  endgenerate

  always_comb begin
    o_slice = '0;
    for (int i = 0; i < NUM_PROJ; i++) begin
      o_slice = o_slice | w_masked[i];
    end
  end

endmodule

// File: rtl/multi_project_io_mux.sv
// Routes one of NUM_PROJ user projects to the shared GPIO pads, with a
// tristated reset guard window on every switch-over and a sticky multi-hot flag.
module multi_project_io_mux
  import mpw_mux_pkg::*;
#(
  parameter int NUM_PROJ     = 8,
  parameter int IO_W         = 38,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NUM_PROJ-1:0]      la_active_i,
  input  logic                     err_clr_i,
  input  logic [NUM_PROJ*IO_W-1:0] proj_io_out_i,
  input  logic [NUM_PROJ*IO_W-1:0] proj_io_oeb_i,
  output logic [IO_W-1:0]          io_out_o,
  output logic [IO_W-1:0]          io_oeb_o,
  output logic [NUM_PROJ-1:0]      proj_rst_o,
  output logic [NUM_PROJ-1:0]      cur_sel_o,
  output logic                     busy_o,
  output logic                     err_multi_o
);

  localparam int CNT_W = $clog2(GUARD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(GUARD_CYCLES - 1);

  state_e              r_state;
  logic [NUM_PROJ-1:0] r_req;
  logic [NUM_PROJ-1:0] r_target;
  logic [CNT_W-1:0]    r_count;
  logic [IO_W-1:0]     r_io_out;
  logic [IO_W-1:0]     r_io_oeb;
  logic [NUM_PROJ-1:0] r_proj_rst;
  logic [NUM_PROJ-1:0] r_cur_sel;
  logic                r_busy;
  logic                r_err;

  state_e              w_state_next;
  logic [NUM_PROJ-1:0] w_target_next;
  logic [CNT_W-1:0]    w_count_next;
  logic                w_err_set;
  req_class_e          w_class;
  logic                w_drive;
  logic [IO_W-1:0]     w_slice_out;
  logic [IO_W-1:0]     w_slice_oeb;

  mpw_slice_select #(.NUM_PROJ(NUM_PROJ), .IO_W(IO_W)) u_sel_out (
    .i_sel   (r_target),
    .i_data  (proj_io_out_i),
    .o_slice (w_slice_out)
  );

  mpw_slice_select #(.NUM_PROJ(NUM_PROJ), .IO_W(IO_W)) u_sel_oeb (
    .i_sel   (r_target),
    .i_data  (proj_io_oeb_i),
    .o_slice (w_slice_oeb)
  );

  always_comb begin
    w_state_next  = r_state;
    w_target_next = r_target;
    w_count_next  = r_count;
    w_err_set     = 1'b0;
    w_class       = classify_req(32'(r_req));
    case (r_state)
      IDLE: begin
        if (w_class == REQ_ONEHOT) begin
          w_state_next  = GUARD;
          w_target_next = r_req;
          w_count_next  = '0;
        end else if (w_class == REQ_MULTI) begin
          w_err_set = 1'b1;
        end
      end
      GUARD: begin
        if (w_class == REQ_MULTI) begin
          w_state_next = IDLE;
          w_err_set    = 1'b1;
        end else if (w_class == REQ_ZERO) begin
          w_state_next = IDLE;
        end else if (r_req != r_target) begin
          w_target_next = r_req;
          w_count_next  = '0;
        end else begin
          w_count_next = r_count + 1'b1;
          if (r_count == LAST_COUNT) begin
            w_state_next = RUN;
          end
        end
      end
      RUN: begin
        if (w_class == REQ_MULTI) begin
          w_state_next = IDLE;
          w_err_set    = 1'b1;
        end else if (w_class == REQ_ZERO) begin
          w_state_next = IDLE;
        end else if (r_req != r_target) begin
          w_state_next  = GUARD;
          w_target_next = r_req;
          w_count_next  = '0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Pads are only driven while RUN persists, so they tristate on the same edge cur_sel clears.
  assign w_drive = (r_state == RUN) && (w_state_next == RUN);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= IDLE;
      r_req      <= '0;
      r_target   <= '0;
      r_count    <= '0;
      r_io_out   <= '0;
      r_io_oeb   <= {IO_W{OEB_DEFAULT}};
      r_proj_rst <= '1;
      r_cur_sel  <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_req      <= la_active_i;
      r_state    <= w_state_next;
      r_target   <= w_target_next;
      r_count    <= w_count_next;
      r_io_out   <= w_drive ? w_slice_out : '0;
      r_io_oeb   <= w_drive ? w_slice_oeb : {IO_W{OEB_DEFAULT}};
      r_proj_rst <= (w_state_next == RUN) ? ~w_target_next : '1;
      r_cur_sel  <= (w_state_next == RUN) ? w_target_next : '0;
      r_busy     <= (w_state_next == GUARD);
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr_i) begin
        r_err <= 1'b0;
      end
    end
  end

  assign io_out_o    = r_io_out;
  assign io_oeb_o    = r_io_oeb;
  assign proj_rst_o  = r_proj_rst;
  assign cur_sel_o   = r_cur_sel;
  assign busy_o      = r_busy;
  assign err_multi_o = r_err;

`ifdef FORMAL
  always_ff @(posedge wb_clk_i) begin
    assert ($onehot0(r_cur_sel));
    assert ((r_cur_sel != '0) || (r_io_oeb == {IO_W{1'b1}}));
    assert ($onehot0(~r_proj_rst));
  end
`endif

endmodule
